// File: rtl/mem_stage_lite_if.sv
// rtl/mem_stage_lite_if.sv - execute-to-memory-stage pipeline bus
//
// Purpose: carries one instruction from the execute stage into the memory
// stage together with the reverse-direction allowin handshake.
// Signals:
//   es_to_ms_valid     execute holds a valid instruction
//   ms_allowin         memory stage accepts an instruction this cycle
//   es_pc              instruction PC
//   es_result          ALU result / virtual address of memory ops
//   es_dest, es_gr_we  destination GPR and its write enable
//   es_load_op         instruction is a load
//   es_mem_size        [0]=byte, [1]=half, 00=word
//   es_mem_sign_exted  sign-extend load data
//   es_excp            exception already detected upstream
//   es_data_req        a data-cache request was accepted in execute
// Modports: master = execute side, slave = memory stage.

interface mem_stage_lite_if;
    logic        es_to_ms_valid;
    logic        ms_allowin;
    logic [31:0] es_pc;
    logic [31:0] es_result;
    logic [4:0]  es_dest;
    logic        es_gr_we;
    logic        es_load_op;
    logic [1:0]  es_mem_size;
    logic        es_mem_sign_exted;
    logic        es_excp;
    logic        es_data_req;

    modport master (
        output es_to_ms_valid, es_pc, es_result, es_dest, es_gr_we,
               es_load_op, es_mem_size, es_mem_sign_exted, es_excp,
               es_data_req,
        input  ms_allowin
    );

    modport slave (
        input  es_to_ms_valid, es_pc, es_result, es_dest, es_gr_we,
               es_load_op, es_mem_size, es_mem_sign_exted, es_excp,
               es_data_req,
        output ms_allowin
    );
endinterface

// File: rtl/mem_stage_lite.sv
// rtl/mem_stage_lite.sv - memory-access pipeline stage between execute and writeback
//
// Purpose: captures execute results, waits for the in-order data-cache
// response of loads/stores, aligns and extends load data, holds a response
// that arrives while writeback stalls, forwards results to decode, and drops
// stale responses belonging to instructions killed by a flush.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   es_bus              execute-to-memory bus (slave side, drives ms_allowin)
//   data_data_ok        one response strobe per accepted cache request
//   data_rdata          load data, valid with data_data_ok
//   flush               pipeline flush from writeback
//   ws_allowin          writeback accepts
//   ms_to_ws_valid      result valid toward writeback
//   ms_pc .. ms_excp    registered instruction fields / final result
//   ms_flush            resident instruction carries an exception
//   ms_fwd_*            forwarding path to decode
//   ms_fwd_stall        resident load whose data is not yet available

module mem_stage_lite #(
    parameter int DISCARD_W = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    mem_stage_lite_if.slave        es_bus,
    input  logic                   data_data_ok,
    input  logic [31:0]            data_rdata,
    input  logic                   flush,
    input  logic                   ws_allowin,
    output logic                   ms_to_ws_valid,
    output logic [31:0]            ms_pc,
    output logic [31:0]            ms_final_result,
    output logic [4:0]             ms_dest,
    output logic                   ms_gr_we,
    output logic                   ms_excp,
    output logic                   ms_flush,
    output logic                   ms_fwd_valid,
    output logic [4:0]             ms_fwd_dest,
    output logic [31:0]            ms_fwd_result,
    output logic                   ms_fwd_stall
);

    // State and payload registers
    logic                 ms_valid_q,     ms_valid_d;
    logic [31:0]          ms_pc_q,        ms_pc_d;
    logic [31:0]          ms_result_q,    ms_result_d;
    logic [4:0]           ms_dest_q,      ms_dest_d;
    logic                 ms_gr_we_q,     ms_gr_we_d;
    logic                 ms_load_op_q,   ms_load_op_d;
    logic [1:0]           ms_mem_size_q,  ms_mem_size_d;
    logic                 ms_sign_q,      ms_sign_d;
    logic                 ms_excp_q,      ms_excp_d;
    logic                 ms_wait_q,      ms_wait_d;
    logic                 buf_valid_q,    buf_valid_d;
    logic [31:0]          rdata_buf_q,    rdata_buf_d;
    logic [DISCARD_W-1:0] discard_cnt_q,  discard_cnt_d;

    // Handshake terms
    logic        fresh_ok;
    logic        ms_ready_go;
    logic        ms_allowin_w;
    logic        ms_leave;
    logic        ms_accept;
    logic        discard_inc;
    logic        discard_dec;

    // Load data path
    logic [31:0] load_rd;
    logic [1:0]  load_addr_lo;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;
    logic [31:0] final_result;

    // A response only belongs to the resident instruction once every
    // response owed to flushed instructions has been swallowed.
    assign fresh_ok     = data_data_ok & (discard_cnt_q == '0);
    assign ms_ready_go  = ms_excp_q | ~ms_wait_q | buf_valid_q | fresh_ok;
    assign ms_allowin_w = ~ms_valid_q | (ms_ready_go & ws_allowin);
    assign ms_leave     = ms_valid_q & ms_ready_go & ws_allowin;
    assign ms_accept    = es_bus.es_to_ms_valid & ms_allowin_w;

    // A flushed instruction still owes a response only if it was waiting and
    // neither already holds its data nor receives it in the flush cycle.
    assign discard_inc  = flush & ms_valid_q & ms_wait_q & ~buf_valid_q & ~fresh_ok;
    assign discard_dec  = data_data_ok & (discard_cnt_q != '0);

    always_comb begin
        ms_valid_d    = ms_valid_q;
        ms_pc_d       = ms_pc_q;
        ms_result_d   = ms_result_q;
        ms_dest_d     = ms_dest_q;
        ms_gr_we_d    = ms_gr_we_q;
        ms_load_op_d  = ms_load_op_q;
        ms_mem_size_d = ms_mem_size_q;
        ms_sign_d     = ms_sign_q;
        ms_excp_d     = ms_excp_q;
        ms_wait_d     = ms_wait_q;
        buf_valid_d   = buf_valid_q;
        rdata_buf_d   = rdata_buf_q;
        discard_cnt_d = discard_cnt_q;

        if (ms_allowin_w) begin
            ms_valid_d = es_bus.es_to_ms_valid;
        end

        // Once the instruction leaves nothing is outstanding; the new
        // occupant (if any) overrides below.
        if (ms_leave) begin
            ms_wait_d   = 1'b0;
            buf_valid_d = 1'b0;
        end

        if (ms_accept) begin
            ms_pc_d       = es_bus.es_pc;
            ms_result_d   = es_bus.es_result;
            ms_dest_d     = es_bus.es_dest;
            ms_gr_we_d    = es_bus.es_gr_we;
            ms_load_op_d  = es_bus.es_load_op;
            ms_mem_size_d = es_bus.es_mem_size;
            ms_sign_d     = es_bus.es_mem_sign_exted;
            ms_excp_d     = es_bus.es_excp;
            ms_wait_d     = es_bus.es_data_req & ~es_bus.es_excp;
        end

        // Response arrives while writeback is stalled: hold it, since
        // data_rdata is only valid in the strobe cycle.
        if (fresh_ok & ms_valid_q & ms_wait_q & ~buf_valid_q & ~ws_allowin) begin
            buf_valid_d = 1'b1;
            rdata_buf_d = data_rdata;
        end

        if (discard_inc & ~discard_dec) begin
            if (discard_cnt_q != '1) begin
                discard_cnt_d = discard_cnt_q + DISCARD_W'(1);
            end
        end else if (discard_dec & ~discard_inc) begin
            discard_cnt_d = discard_cnt_q - DISCARD_W'(1);
        end

        // Flush kills the resident instruction and any incoming one; the
        // wait/buffer flags must never outlive ms_valid.
        if (flush) begin
            ms_valid_d  = 1'b0;
            ms_wait_d   = 1'b0;
            buf_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_q    <= 1'b0;
            ms_pc_q       <= '0;
            ms_result_q   <= '0;
            ms_dest_q     <= '0;
            ms_gr_we_q    <= 1'b0;
            ms_load_op_q  <= 1'b0;
            ms_mem_size_q <= '0;
            ms_sign_q     <= 1'b0;
            ms_excp_q     <= 1'b0;
            ms_wait_q     <= 1'b0;
            buf_valid_q   <= 1'b0;
            rdata_buf_q   <= '0;
            discard_cnt_q <= '0;
        end else begin
            ms_valid_q    <= ms_valid_d;
            ms_pc_q       <= ms_pc_d;
            ms_result_q   <= ms_result_d;
            ms_dest_q     <= ms_dest_d;
            ms_gr_we_q    <= ms_gr_we_d;
            ms_load_op_q  <= ms_load_op_d;
            ms_mem_size_q <= ms_mem_size_d;
            ms_sign_q     <= ms_sign_d;
            ms_excp_q     <= ms_excp_d;
            ms_wait_q     <= ms_wait_d;
            buf_valid_q   <= buf_valid_d;
            rdata_buf_q   <= rdata_buf_d;
            discard_cnt_q <= discard_cnt_d;
        end
    end

    // Load alignment and extension
    always_comb begin
        load_rd      = buf_valid_q ? rdata_buf_q : data_rdata;
        load_addr_lo = ms_result_q[1:0];
        load_byte    = 8'h00;
        case (load_addr_lo)
            2'b00:   load_byte = load_rd[7:0];
            2'b01:   load_byte = load_rd[15:8];
            2'b10:   load_byte = load_rd[23:16];
            default: load_byte = load_rd[31:24];
        endcase
        load_half = load_addr_lo[1] ? load_rd[31:16] : load_rd[15:0];

        if (ms_mem_size_q[0]) begin
            load_data = {{24{ms_sign_q & load_byte[7]}}, load_byte};
        end else if (ms_mem_size_q[1]) begin
            load_data = {{16{ms_sign_q & load_half[15]}}, load_half};
        end else begin
            load_data = load_rd;
        end

        final_result = (ms_load_op_q & ~ms_excp_q) ? load_data : ms_result_q;
    end

    assign es_bus.ms_allowin = ms_allowin_w;
    assign ms_to_ws_valid    = ms_valid_q & ms_ready_go;
    assign ms_pc             = ms_pc_q;
    assign ms_final_result   = final_result;
    assign ms_dest           = ms_dest_q;
    assign ms_gr_we          = ms_gr_we_q;
    assign ms_excp           = ms_excp_q;
    assign ms_flush          = ms_valid_q & ms_excp_q;
    assign ms_fwd_valid      = ms_valid_q & ms_gr_we_q & (ms_dest_q != 5'd0);
    assign ms_fwd_dest       = ms_dest_q;
    assign ms_fwd_result     = final_result;
    assign ms_fwd_stall      = ms_valid_q & ms_load_op_q & ~ms_ready_go;

endmodule

// File: tb/tb_mem_stage_lite.sv
// tb/tb_mem_stage_lite.sv - directed self-checking bench for mem_stage_lite

module tb_mem_stage_lite;

    logic        clk = 1'b0;
    logic        reset;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        flush;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [31:0] ms_pc;
    logic [31:0] ms_final_result;
    logic [4:0]  ms_dest;
    logic        ms_gr_we;
    logic        ms_excp;
    logic        ms_flush;
    logic        ms_fwd_valid;
    logic [4:0]  ms_fwd_dest;
    logic [31:0] ms_fwd_result;
    logic        ms_fwd_stall;

    int checks = 0;
    int errors = 0;

    mem_stage_lite_if es_bus ();

    mem_stage_lite #(.DISCARD_W(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .es_bus          (es_bus),
        .data_data_ok    (data_data_ok),
        .data_rdata      (data_rdata),
        .flush           (flush),
        .ws_allowin      (ws_allowin),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_pc           (ms_pc),
        .ms_final_result (ms_final_result),
        .ms_dest         (ms_dest),
        .ms_gr_we        (ms_gr_we),
        .ms_excp         (ms_excp),
        .ms_flush        (ms_flush),
        .ms_fwd_valid    (ms_fwd_valid),
        .ms_fwd_dest     (ms_fwd_dest),
        .ms_fwd_result   (ms_fwd_result),
        .ms_fwd_stall    (ms_fwd_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic set_es(input logic valid, input logic [31:0] pc, input logic [31:0] res,
                          input logic [4:0] dest, input logic gr_we, input logic load,
                          input logic [1:0] size, input logic sign, input logic excp,
                          input logic req);
        es_bus.es_to_ms_valid    = valid;
        es_bus.es_pc             = pc;
        es_bus.es_result         = res;
        es_bus.es_dest           = dest;
        es_bus.es_gr_we          = gr_we;
        es_bus.es_load_op        = load;
        es_bus.es_mem_size       = size;
        es_bus.es_mem_sign_exted = sign;
        es_bus.es_excp           = excp;
        es_bus.es_data_req       = req;
    endtask

    // Issue a load, answer it on the next cycle with writeback ready.
    task automatic load_once(input string tag, input logic [31:0] addr, input logic [1:0] size,
                             input logic sign, input logic [31:0] rdata, input logic [31:0] exp);
        set_es(1'b1, addr + 32'h100, addr, 5'd3, 1'b1, 1'b1, size, sign, 1'b0, 1'b1);
        settle();
        check({tag, "_allowin"}, 32'(es_bus.ms_allowin), 32'd1);
        step();
        es_bus.es_to_ms_valid = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = rdata;
        settle();
        check({tag, "_valid"}, 32'(ms_to_ws_valid), 32'd1);
        check({tag, "_result"}, ms_final_result, exp);
        step();
        data_data_ok = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
        flush        = 1'b0;
        ws_allowin   = 1'b1;
        set_es(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        step();
        step();
        reset = 1'b0;
        settle();

        // Reset state
        check("rst_allowin", 32'(es_bus.ms_allowin), 32'd1);
        check("rst_valid", 32'(ms_to_ws_valid), 32'd0);
        check("rst_pc", ms_pc, 32'h0);
        check("rst_result", ms_final_result, 32'h0);
        check("rst_flush", 32'(ms_flush), 32'd0);
        check("rst_fwd_stall", 32'(ms_fwd_stall), 32'd0);
        check("rst_fwd_valid", 32'(ms_fwd_valid), 32'd0);

        // ld.w at 0x1000, response two cycles after entry
        set_es(1'b1, 32'h0000_0400, 32'h0000_1000, 5'd5, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1);
        step();
        es_bus.es_to_ms_valid = 1'b0;
        settle();
        check("ldw_stall", 32'(ms_fwd_stall), 32'd1);
        check("ldw_not_valid", 32'(ms_to_ws_valid), 32'd0);
        check("ldw_allowin", 32'(es_bus.ms_allowin), 32'd0);
        check("ldw_fwd_valid", 32'(ms_fwd_valid), 32'd1);
        check("ldw_pc", ms_pc, 32'h0000_0400);
        step();
        data_data_ok = 1'b1;
        data_rdata   = 32'hDEAD_BEEF;
        settle();
        check("ldw_valid", 32'(ms_to_ws_valid), 32'd1);
        check("ldw_result", ms_final_result, 32'hDEAD_BEEF);
        check("ldw_fwd_result", ms_fwd_result, 32'hDEAD_BEEF);
        check("ldw_fwd_dest", 32'(ms_fwd_dest), 32'd5);
        check("ldw_no_stall", 32'(ms_fwd_stall), 32'd0);
        step();
        data_data_ok = 1'b0;
        settle();
        check("ldw_gone", 32'(ms_to_ws_valid), 32'd0);
        check("ldw_gone_allowin", 32'(es_bus.ms_allowin), 32'd1);

        // Alignment and extension
        load_once("ldb", 32'h0000_2003, 2'b01, 1'b1, 32'h8012_3456, 32'hFFFF_FF80);
        load_once("ldbu", 32'h0000_2003, 2'b01, 1'b0, 32'h8012_3456, 32'h0000_0080);
        load_once("ldh", 32'h0000_2002, 2'b10, 1'b1, 32'h8012_3456, 32'hFFFF_8012);
        load_once("ldhu0", 32'h0000_2000, 2'b10, 1'b0, 32'h8012_3456, 32'h0000_3456);
        load_once("ldb1", 32'h0000_2001, 2'b01, 1'b1, 32'h8012_3456, 32'h0000_0034);
        load_once("ldb0", 32'h0000_2004, 2'b01, 1'b1, 32'h0000_00F0, 32'hFFFF_FFF0);

        // Response buffered while writeback stalls for three cycles
        set_es(1'b1, 32'h0000_0500, 32'h0000_3000, 5'd4, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
        step();
        es_bus.es_to_ms_valid = 1'b0;
        ws_allowin   = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = 32'hCAFE_F00D;
        settle();
        check("buf_ready", 32'(ms_to_ws_valid), 32'd1);
        check("buf_allowin", 32'(es_bus.ms_allowin), 32'd0);
        step();
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
        for (int i = 0; i < 2; i++) begin
            settle();
            check("buf_hold_valid", 32'(ms_to_ws_valid), 32'd1);
            check("buf_hold_result", ms_final_result, 32'hCAFE_F00D);
            step();
        end
        ws_allowin = 1'b1;
        settle();
        check("buf_issue_valid", 32'(ms_to_ws_valid), 32'd1);
        check("buf_issue_result", ms_final_result, 32'hCAFE_F00D);
        check("buf_issue_allowin", 32'(es_bus.ms_allowin), 32'd1);
        step();
        settle();
        check("buf_cleared_valid", 32'(ms_to_ws_valid), 32'd0);
        // A new load must wait again, so the buffer is empty
        set_es(1'b1, 32'h0000_0504, 32'h0000_3004, 5'd4, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
        step();
        es_bus.es_to_ms_valid = 1'b0;
        settle();
        check("buf_empty_stall", 32'(ms_fwd_stall), 32'd1);
        data_data_ok = 1'b1;
        data_rdata   = 32'h0000_0777;
        settle();
        check("buf_next_result", ms_final_result, 32'h0000_0777);
        step();
        data_data_ok = 1'b0;

        // Flush of an outstanding load, stale response dropped
        set_es(1'b1, 32'h0000_0600, 32'h0000_4000, 5'd6, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
        step();
        es_bus.es_to_ms_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        settle();
        check("fl_killed", 32'(ms_to_ws_valid), 32'd0);
        check("fl_allowin", 32'(es_bus.ms_allowin), 32'd1);
        set_es(1'b1, 32'h0000_0700, 32'h0000_5000, 5'd7, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
        step();
        es_bus.es_to_ms_valid = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = 32'h0000_1111;
        settle();
        check("fl_drop_valid", 32'(ms_to_ws_valid), 32'd0);
        check("fl_drop_stall", 32'(ms_fwd_stall), 32'd1);
        step();
        data_rdata = 32'h0000_2222;
        settle();
        check("fl_new_valid", 32'(ms_to_ws_valid), 32'd1);
        check("fl_new_result", ms_final_result, 32'h0000_2222);
        step();
        data_data_ok = 1'b0;
        // Counter back to zero: next load completes on its first response
        load_once("fl_after", 32'h0000_5100, 2'b00, 1'b0, 32'h0000_3333, 32'h0000_3333);

        // Instruction with an exception and no cache request
        set_es(1'b1, 32'h0000_0800, 32'h0000_6000, 5'd8, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
        step();
        es_bus.es_to_ms_valid = 1'b0;
        settle();
        check("ex_valid", 32'(ms_to_ws_valid), 32'd1);
        check("ex_flush", 32'(ms_flush), 32'd1);
        check("ex_excp", 32'(ms_excp), 32'd1);
        check("ex_result", ms_final_result, 32'h0000_6000);
        step();

        // Store: waits for its response, gr_we=0, result is the address
        set_es(1'b1, 32'h0000_0900, 32'h0000_7000, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        step();
        es_bus.es_to_ms_valid = 1'b0;
        settle();
        check("st_wait", 32'(ms_to_ws_valid), 32'd0);
        check("st_gr_we", 32'(ms_gr_we), 32'd0);
        data_data_ok = 1'b1;
        data_rdata   = 32'h5555_5555;
        settle();
        check("st_valid", 32'(ms_to_ws_valid), 32'd1);
        check("st_result", ms_final_result, 32'h0000_7000);
        step();
        data_data_ok = 1'b0;

        // ALU op forwarding and writeback backpressure
        set_es(1'b1, 32'h0000_0A00, 32'h1234_5678, 5'd9, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        step();
        es_bus.es_to_ms_valid = 1'b0;
        ws_allowin = 1'b0;
        settle();
        check("alu_valid", 32'(ms_to_ws_valid), 32'd1);
        check("alu_fwd_valid", 32'(ms_fwd_valid), 32'd1);
        check("alu_fwd_dest", 32'(ms_fwd_dest), 32'd9);
        check("alu_fwd_result", ms_fwd_result, 32'h1234_5678);
        check("alu_allowin_stall", 32'(es_bus.ms_allowin), 32'd0);
        ws_allowin = 1'b1;
        step();

        // Flush and incoming instruction in the same cycle: flush wins
        set_es(1'b1, 32'h0000_0B00, 32'h0000_0042, 5'd10, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        es_bus.es_to_ms_valid = 1'b0;
        settle();
        check("flwin_valid", 32'(ms_to_ws_valid), 32'd0);
        check("flwin_fwd_valid", 32'(ms_fwd_valid), 32'd0);

        // Reset mid-wait with a stale response still owed
        set_es(1'b1, 32'h0000_0C00, 32'h0000_8000, 5'd11, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
        step();
        es_bus.es_to_ms_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        set_es(1'b1, 32'h0000_0D00, 32'h0000_9000, 5'd12, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
        step();
        es_bus.es_to_ms_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        settle();
        check("rst2_allowin", 32'(es_bus.ms_allowin), 32'd1);
        check("rst2_valid", 32'(ms_to_ws_valid), 32'd0);
        check("rst2_pc", ms_pc, 32'h0);
        check("rst2_dest", 32'(ms_dest), 32'd0);
        check("rst2_result", ms_final_result, 32'h0);
        check("rst2_stall", 32'(ms_fwd_stall), 32'd0);
        load_once("rst2_after", 32'h0000_A000, 2'b00, 1'b0, 32'h4444_4444, 32'h4444_4444);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
